// File: rtl/spi_arb_master.sv
// Two-client SPI master: round-robin arbitration between two requesters, one
// full-duplex DW-bit MSB-first transfer per grant on a shared bus.
module spi_arb_master #(
    parameter int DW   = 32,
    parameter int CPOL = 0,
    parameter int DIV  = 2,
    parameter int SW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DW-1:0]   req_data,
    input  logic [2*SW-1:0]   req_sel,
    output logic [1:0]        resp_valid,
    output logic [DW-1:0]     resp_data,
    output logic              busy,
    output logic [2**SW-1:0]  spi_cs_n,
    output logic              spi_sck,
    output logic              spi_copi,
    input  logic              spi_cipo
);

    localparam int NCS = 2**SW;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(DW - 1);
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            owner;
    logic [DW-1:0]   tx_sr;
    logic [DW-1:0]   rx_sr;
    logic [5:0]      bit_cnt;
    logic [PW-1:0]   phase;
    logic            half;

    logic [1:0]      grant;
    logic            acc_idx;
    logic [DW-1:0]   acc_data;
    logic [SW-1:0]   acc_sel;

    // With both requesters pending, the one that was not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign acc_idx   = grant[1];
    assign acc_data  = acc_idx ? req_data[DW +: DW] : req_data[0 +: DW];
    assign acc_sel   = acc_idx ? req_sel[SW +: SW] : req_sel[0 +: SW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            spi_cs_n   <= '1;
            spi_sck    <= SCK_IDLE;
            spi_copi   <= 1'b0;
            resp_valid <= 2'b00;
            resp_data  <= '0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            phase      <= '0;
            half       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        owner      <= acc_idx;
                        last_grant <= acc_idx;
                        tx_sr      <= acc_data;
                        spi_cs_n   <= ~(NCS'(1) << acc_sel);
                        phase      <= '0;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase == PH_LAST) begin
                        phase    <= '0;
                        half     <= 1'b0;
                        bit_cnt  <= BIT_LAST;
                        spi_sck  <= ~SCK_IDLE;
                        spi_copi <= tx_sr[DW-1];
                        tx_sr    <= {tx_sr[DW-2:0], 1'b0};
                        state    <= SHIFT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SHIFT: begin
                    // half=0: active half of a bit period; half=1: idle half.
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (!half) begin
                            half    <= 1'b1;
                            spi_sck <= SCK_IDLE;
                            rx_sr   <= {rx_sr[DW-2:0], spi_cipo};
                        end else if (bit_cnt == 6'd0) begin
                            spi_copi <= 1'b0;
                            state    <= HOLD;
                        end else begin
                            half     <= 1'b0;
                            bit_cnt  <= bit_cnt - 1'b1;
                            spi_sck  <= ~SCK_IDLE;
                            spi_copi <= tx_sr[DW-1];
                            tx_sr    <= {tx_sr[DW-2:0], 1'b0};
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HOLD: begin
                    if (phase == PH_LAST) begin
                        phase      <= '0;
                        spi_cs_n   <= '1;
                        resp_valid <= owner ? 2'b10 : 2'b01;
                        resp_data  <= rx_sr;
                        state      <= GAP;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                GAP: begin
                    resp_valid <= 2'b00;
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb_master.sv
// Bench for spi_arb_master: instance A (DW=32, CPOL=0, DIV=2) and instance B
// (DW=16, CPOL=1, DIV=1), each with behavioural SPI peripherals and a scoreboard.
module tb_spi_arb_master;

    localparam int ADIV = 2;
    localparam int A_LAT = 2*ADIV*(32+1)+1;
    localparam int B_LAT = 2*1*(16+1)+1;
    localparam logic [31:0] ROM_A0 = 32'hDEADBEEF;
    localparam logic [31:0] ROM_A1 = 32'h12345678;
    localparam logic [15:0] ROM_B  = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Instance A signals
    logic        a_rst;
    logic [1:0]  a_req_valid, a_req_ready, a_resp_valid, a_cs_n;
    logic [63:0] a_req_data;
    logic [1:0]  a_req_sel;
    logic [31:0] a_resp_data;
    logic        a_busy, a_sck, a_copi, a_cipo;

    // Instance B signals
    logic        b_rst;
    logic [1:0]  b_req_valid, b_req_ready, b_resp_valid, b_cs_n;
    logic [31:0] b_req_data;
    logic [1:0]  b_req_sel;
    logic [15:0] b_resp_data;
    logic        b_busy, b_sck, b_copi, b_cipo;

    spi_arb_master #(.DW(32), .CPOL(0), .DIV(ADIV), .SW(1)) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_data(a_req_data), .req_sel(a_req_sel), .resp_valid(a_resp_valid),
        .resp_data(a_resp_data), .busy(a_busy), .spi_cs_n(a_cs_n), .spi_sck(a_sck),
        .spi_copi(a_copi), .spi_cipo(a_cipo)
    );

    spi_arb_master #(.DW(16), .CPOL(1), .DIV(1), .SW(1)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_data(b_req_data), .req_sel(b_req_sel), .resp_valid(b_resp_valid),
        .resp_data(b_resp_data), .busy(b_busy), .spi_cs_n(b_cs_n), .spi_sck(b_sck),
        .spi_copi(b_copi), .spi_cipo(b_cipo)
    );

    // Peripherals on bus A (mode CPOL=0): drive CIPO on rising SCK, sample COPI on falling.
    logic [31:0] ma_tx0 = '0, ma_tx1 = '0, ma_rx0 = '0, ma_rx1 = '0;
    logic        ma_out0 = 1'b0, ma_out1 = 1'b0, ma_sck_p = 1'b0;
    logic [1:0]  ma_cs_p = 2'b11;
    int          ma_edges0 = 0, ma_edges1 = 0, ma_tot0 = 0, ma_bad = 0;

    always @(a_sck or a_cs_n) begin
        if (a_cs_n[0] === 1'b0 && ma_cs_p[0] !== 1'b0) begin ma_tx0 = ROM_A0; ma_edges0 = 0; end
        if (a_cs_n[1] === 1'b0 && ma_cs_p[1] !== 1'b0) begin ma_tx1 = ROM_A1; ma_edges1 = 0; end
        if (a_sck === 1'b1 && ma_sck_p === 1'b0) begin
            if (a_rst === 1'b0 && a_cs_n === 2'b11) ma_bad++;
            if (a_cs_n[0] === 1'b0) begin
                ma_out0 = ma_tx0[31]; ma_tx0 = {ma_tx0[30:0], 1'b0}; ma_edges0++; ma_tot0++;
            end
            if (a_cs_n[1] === 1'b0) begin
                ma_out1 = ma_tx1[31]; ma_tx1 = {ma_tx1[30:0], 1'b0}; ma_edges1++;
            end
        end else if (a_sck === 1'b0 && ma_sck_p === 1'b1) begin
            if (a_rst === 1'b0 && a_cs_n === 2'b11) ma_bad++;
            if (a_cs_n[0] === 1'b0) ma_rx0 = {ma_rx0[30:0], a_copi};
            if (a_cs_n[1] === 1'b0) ma_rx1 = {ma_rx1[30:0], a_copi};
        end
        ma_sck_p = a_sck;
        ma_cs_p  = a_cs_n;
    end

    assign a_cipo = (a_cs_n[0] === 1'b0) ? ma_out0 : (a_cs_n[1] === 1'b0) ? ma_out1 : 1'b0;

    // Peripheral on bus B (mode CPOL=1): active edge is falling SCK.
    logic [15:0] mb_tx = '0, mb_rx = '0;
    logic        mb_out = 1'b0, mb_sck_p = 1'b1, mb_cs_p = 1'b1;
    int          mb_edges = 0, mb_bad = 0;

    always @(b_sck or b_cs_n) begin
        if (b_cs_n[0] === 1'b0 && mb_cs_p !== 1'b0) begin mb_tx = ROM_B; mb_edges = 0; end
        if (b_sck === 1'b0 && mb_sck_p === 1'b1) begin
            if (b_rst === 1'b0 && b_cs_n === 2'b11) mb_bad++;
            if (b_cs_n[0] === 1'b0) begin
                mb_out = mb_tx[15]; mb_tx = {mb_tx[14:0], 1'b0}; mb_edges++;
            end
        end else if (b_sck === 1'b1 && mb_sck_p === 1'b0) begin
            if (b_rst === 1'b0 && b_cs_n === 2'b11) mb_bad++;
            if (b_cs_n[0] === 1'b0) mb_rx = {mb_rx[14:0], b_copi};
        end
        mb_sck_p = b_sck;
        mb_cs_p  = b_cs_n[0];
    end

    assign b_cipo = (b_cs_n[0] === 1'b0) ? mb_out : 1'b0;

    // Scoreboards: A entry = {owner[1:0], sel, copi word, expected cipo word}
    logic [66:0] a_exp_q[$];
    logic [33:0] b_exp_q[$];
    int   a_grant_log[$];
    int   a_left [2] = '{0, 0};
    bit   a_drop [2] = '{1'b0, 1'b0};
    int   a_acc_cyc = 0, a_resp_cyc = 0, a_resp_cnt = 0, a_cs0_falls = 0;
    logic [1:0] a_cs_prev = 2'b11;
    bit   a_gap_chk = 1'b0, a_gap_armed = 1'b0;
    int   a_gap_seen = 0;
    int   b_left = 0, b_acc_cyc = 0;
    bit   b_drop = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of bookkeeping: sample at negedge, update drives just after posedge.
    task automatic tick();
        logic [66:0] ea;
        logic [33:0] eb;
        logic        s;
        @(negedge clk);
        #1;
        if (a_rst === 1'b0) begin
            for (int i = 0; i < 2; i++) begin
                if (a_req_valid[i] && a_req_ready[i] === 1'b1) begin
                    s = a_req_sel[i];
                    a_exp_q.push_back({(i == 0) ? 2'b01 : 2'b10, s, a_req_data[i*32 +: 32],
                                       s ? ROM_A1 : ROM_A0});
                    a_acc_cyc = cyc;
                    a_grant_log.push_back(i);
                    a_left[i]--;
                    if (a_left[i] <= 0) a_drop[i] = 1'b1;
                end
            end
            if (a_resp_valid !== 2'b00) begin
                if (a_exp_q.size() == 0) begin
                    check("a_unexpected_resp", 64'(a_resp_valid), 64'd0);
                end else begin
                    ea = a_exp_q.pop_front();
                    check("a_resp_owner", 64'(a_resp_valid), 64'(ea[66:65]));
                    check("a_resp_data", 64'(a_resp_data), 64'(ea[31:0]));
                    check("a_latency", 64'(cyc - a_acc_cyc), 64'(A_LAT));
                    check("a_model_copi", 64'(ea[64] ? ma_rx1 : ma_rx0), 64'(ea[63:32]));
                    check("a_sck_pulses", 64'(ea[64] ? ma_edges1 : ma_edges0), 64'd32);
                    a_resp_cyc = cyc;
                    a_resp_cnt++;
                    a_gap_armed = a_gap_chk;
                end
            end
            if (a_cs_prev == 2'b11 && a_cs_n != 2'b11 && a_gap_armed) begin
                check("a_gap_cycles", 64'(cyc - a_resp_cyc), 64'(ADIV + 1));
                a_gap_seen++;
                a_gap_armed = 1'b0;
            end
            if (a_cs_prev[0] === 1'b1 && a_cs_n[0] === 1'b0) a_cs0_falls++;
        end
        a_cs_prev = a_cs_n;
        if (b_rst === 1'b0) begin
            if (b_req_valid[0] && b_req_ready[0] === 1'b1) begin
                b_exp_q.push_back({2'b01, b_req_data[15:0], ROM_B});
                b_acc_cyc = cyc;
                b_left--;
                if (b_left <= 0) b_drop = 1'b1;
            end
            if (b_resp_valid !== 2'b00) begin
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected_resp", 64'(b_resp_valid), 64'd0);
                end else begin
                    eb = b_exp_q.pop_front();
                    check("b_resp_owner", 64'(b_resp_valid), 64'(eb[33:32]));
                    check("b_resp_data", 64'(b_resp_data), 64'(eb[15:0]));
                    check("b_latency", 64'(cyc - b_acc_cyc), 64'(B_LAT));
                    check("b_model_copi", 64'(mb_rx), 64'(eb[31:16]));
                    check("b_sck_pulses", 64'(mb_edges), 64'd16);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (a_drop[i]) begin a_req_valid[i] = 1'b0; a_drop[i] = 1'b0; end
        end
        if (b_drop) begin b_req_valid[0] = 1'b0; b_drop = 1'b0; end
    endtask

    task automatic a_req(input int i, input logic [31:0] d, input logic s, input int n);
        a_req_data[i*32 +: 32] = d;
        a_req_sel[i] = s;
        a_req_valid[i] = 1'b1;
        a_left[i] = n;
    endtask

    task automatic a_run(input int budget);
        int n = 0;
        while ((a_left[0] > 0 || a_left[1] > 0 || a_exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("a_run_done", 64'(n < budget), 64'd1);
        a_req_valid = 2'b00;
        a_left = '{0, 0};
        a_exp_q.delete();
    endtask

    task automatic b_run(input int budget);
        int n = 0;
        while ((b_left > 0 || b_exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("b_run_done", 64'(n < budget), 64'd1);
        b_req_valid = 2'b00;
        b_left = 0;
        b_exp_q.delete();
    endtask

    initial begin
        int n;
        int t0;
        int f0;
        int rc;
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = '0; a_req_data = '0; a_req_sel = '0;
        b_req_valid = '0; b_req_data = '0; b_req_sel = '0;
        repeat (3) tick();

        check("a_rst_cs_n", 64'(a_cs_n), 64'h3);
        check("a_rst_sck", 64'(a_sck), 64'd0);
        check("a_rst_copi", 64'(a_copi), 64'd0);
        check("a_rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("a_rst_resp_data", 64'(a_resp_data), 64'd0);
        check("a_rst_busy", 64'(a_busy), 64'd0);
        check("a_rst_ready", 64'(a_req_ready), 64'd0);
        check("b_rst_sck", 64'(b_sck), 64'd1);
        check("b_rst_cs_n", 64'(b_cs_n), 64'h3);
        check("b_rst_resp_data", 64'(b_resp_data), 64'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) tick();
        check("a_idle_busy", 64'(a_busy), 64'd0);
        check("b_idle_sck", 64'(b_sck), 64'd1);

        // Single transfer from requester 0 to chip select 0
        a_req(0, 32'h0000_0041, 1'b0, 1);
        a_run(400);
        repeat (2) tick();
        check("a_busy_after", 64'(a_busy), 64'd0);
        check("a_resp_data_held", 64'(a_resp_data), 64'(ROM_A0));
        check("a_resp_valid_low", 64'(a_resp_valid), 64'd0);

        // Chip-select routing: sel=1 must leave cs_n[0] and peripheral 0 untouched
        t0 = ma_tot0;
        f0 = a_cs0_falls;
        a_req(1, 32'h0000_009A, 1'b1, 1);
        a_run(400);
        check("a_cs0_untouched_edges", 64'(ma_tot0 - t0), 64'd0);
        check("a_cs0_no_fall", 64'(a_cs0_falls - f0), 64'd0);

        // Reset in the middle of SHIFT, at bit 10
        a_req(0, 32'h55AA_1234, 1'b0, 1);
        n = 0;
        while (ma_edges0 != 22 && n < 400) begin tick(); n++; end
        check("a_reach_bit10", 64'(n < 400), 64'd1);
        a_rst = 1'b1;
        a_req_valid = 2'b00;
        a_left = '{0, 0};
        a_drop = '{1'b0, 1'b0};
        #1;
        check("a_abort_cs_n", 64'(a_cs_n), 64'h3);
        check("a_abort_sck", 64'(a_sck), 64'd0);
        check("a_abort_busy", 64'(a_busy), 64'd0);
        a_exp_q.delete();
        rc = a_resp_cnt;
        repeat (3) tick();
        a_rst = 1'b0;
        repeat (150) tick();
        check("a_abort_no_resp", 64'(a_resp_cnt - rc), 64'd0);
        a_req(0, 32'h0000_0041, 1'b0, 1);
        a_run(400);

        // Contention right after reset: order must alternate 0,1,0,1
        a_rst = 1'b1;
        repeat (2) tick();
        a_rst = 1'b0;
        tick();
        a_grant_log.delete();
        a_req(0, 32'h0000_0011, 1'b0, 2);
        a_req(1, 32'h0000_0022, 1'b1, 2);
        a_run(1200);
        check("a_grant_count", 64'(a_grant_log.size()), 64'd4);
        for (int k = 0; k < a_grant_log.size(); k++)
            check("a_grant_order", 64'(a_grant_log[k]), 64'(k % 2));

        // Back-to-back: requester 0 held for three words
        a_gap_chk = 1'b1;
        a_gap_seen = 0;
        a_grant_log.delete();
        a_req(0, 32'h0000_0077, 1'b0, 3);
        a_run(1200);
        a_gap_chk = 1'b0;
        a_gap_armed = 1'b0;
        check("a_b2b_gaps", 64'(a_gap_seen), 64'd2);
        check("a_b2b_grants", 64'(a_grant_log.size()), 64'd3);

        // Instance B: CPOL=1, DIV=1, DW=16
        b_req_data[15:0] = 16'h3C5A;
        b_req_sel[0] = 1'b0;
        b_req_valid[0] = 1'b1;
        b_left = 1;
        b_run(200);
        tick();
        check("b_sck_idle_high", 64'(b_sck), 64'd1);
        check("b_cs_released", 64'(b_cs_n), 64'h3);

        check("a_sck_edge_cs_high", 64'(ma_bad), 64'd0);
        check("b_sck_edge_cs_high", 64'(mb_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_arb_master.md
Name: spi_arb_master

Overview:
- Two-requester SPI master that shares one SPI bus, with up to 2**SW chip selects, between two independent clients (e.g. CPU bus bridge and config sequencer).
- Round-robin arbitration; runs one full-duplex DW-bit transfer per grant, MSB first.
- Mode: peripheral changes CIPO on the SCK active edge and samples COPI on the return-to-idle edge.
- Drives spi_model-compatible peripherals in simulation and real devices on the board.

Parameters:
- DW, 32, transfer width in bits (2..32).
- CPOL, 0, SCK idle level.
- DIV, 2, SCK half-period in clk cycles (>=1).
- SW, 1, chip-select index width; NCS = 2**SW chip selects.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  request i pending; must be held until req_ready[i].
- req_ready  out  2  one-hot accept strobe, 1 cycle.
- req_data  in  2*DW  COPI word; requester i uses [i*DW +: DW].
- req_sel  in  2*SW  chip-select index; requester i uses [i*SW +: SW].
- resp_valid  out  2  one-hot, 1-cycle pulse to the requester that owned the transfer.
- resp_data  out  DW  CIPO word captured; valid while resp_valid is high, held until the next capture.
- busy  out  1  high in every state except IDLE.
- spi_cs_n  out  NCS  active-low chip selects.
- spi_sck  out  1  SPI clock.
- spi_copi  out  1  controller-out data.
- spi_cipo  in  1  controller-in data.

Behaviour:
- Reset (asynchronous, takes effect mid-transfer too): state=IDLE; spi_cs_n all 1; spi_sck=CPOL; spi_copi=0; req_ready=0; resp_valid=0; resp_data=0; busy=0; last_grant=1. Any aborted transfer produces no resp_valid.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. All outputs are registered except req_ready.
- IDLE:
  - req_ready[i] = (state==IDLE) & grant[i], combinational.
  - Grant rule: only one valid -> that one. Both valid -> the requester != last_grant.
  - On accept (valid&ready edge): latch data and sel, set last_grant=i, go to SETUP.
- SETUP:
  - spi_cs_n[sel]=0 from the first cycle after accept. Lasts DIV cycles with sck idle.
- SHIFT:
  - DW bit periods of 2*DIV cycles each, bit index DW-1 down to 0.
  - First DIV cycles: sck=~CPOL, with spi_copi set to the current bit on the same clk edge that drives sck active.
  - Last DIV cycles: sck=CPOL.
  - spi_cipo is sampled on the clk edge that returns sck to idle and shifted into resp_data's shadow register, LSB end.
  - 6-bit bit counter and DIV-width phase counter. SHIFT exits after the last bit's idle half.
- HOLD:
  - DIV cycles, cs still low, sck idle, copi=0.
- GAP:
  - On entry: all cs_n high; resp_valid[owner]=1 for exactly that cycle; resp_data updated the same cycle.
  - Lasts DIV cycles, then IDLE. No acceptance during GAP.
- Latency: accept edge to resp_valid = 2*DIV*(DW+1)+1 clk cycles, e.g. 133 for DW=32, DIV=2.
- Earliest next accept: DIV cycles after resp_valid.
- Exactly DW active SCK pulses per transfer; no SCK edges while any cs_n is high.
- A requester that drops req_valid before ready is simply not served; no state is kept for it.
- Non-selected chip selects stay high throughout.

Test Plan:
- Single transfer: req0 data=0x00000041, sel=0; spi_model ID0 ROM=0xDEADBEEF -> resp_valid=2'b01 exactly 133 cycles after accept, resp_data=0xDEADBEEF. Exactly 32 SCK rising edges. Model shift register holds 0x00000041.
- Contention: both valid in the same cycle after reset -> req0 served first, then req1 (sel=1, ROM 0x12345678, resp_valid=2'b10, resp_data=0x12345678). Repeat both -> order alternates 0,1,0,1.
- Back-to-back: req0 held valid for 3 words, req1 idle -> three grants to req0, each returning 0xDEADBEEF. Gap between resp_valid and the next cs_n fall is DIV+1 cycles.
- Chip-select routing, SW=1: sel=1 -> only spi_cs_n[1] toggles; spi_cs_n[0] is constantly 1 and model 0 sees no edges.
- Reset mid-SHIFT at bit 10: asserting rst -> cs_n=all 1 and sck=CPOL in the same cycle, no resp_valid. After release, a new req0 completes normally with correct data.
- CPOL=1, DIV=1, DW=16: model with CPOL=1, ROM=0xA5C3, send 0x3C5A -> resp_data=0xA5C3. sck idles high. Latency = 2*1*17+1 = 35 cycles.
